// File: rtl/cdc_mux_pkg.sv
// Shared types and helpers for the synchronizer datapath collector stage.
// Holds the collector state encoding, source indices and round-robin pick.
package cdc_mux_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DRAIN
    } collector_state_t;

    localparam int unsigned SEL_WIDTH = 2;

    localparam logic [SEL_WIDTH-1:0] SRC_A = 2'd0;
    localparam logic [SEL_WIDTH-1:0] SRC_B = 2'd1;
    localparam logic [SEL_WIDTH-1:0] SRC_C = 2'd2;
    localparam logic [SEL_WIDTH-1:0] SRC_D = 2'd3;

    // Scan last+1, last+2, last+3, last (mod 4); the 2-bit add wraps naturally.
    // With no request set the previous owner is returned unchanged.
    function automatic logic [SEL_WIDTH-1:0] rr_pick(
        input logic [3:0]           req,
        input logic [SEL_WIDTH-1:0] last
    );
        logic [SEL_WIDTH-1:0] idx;
        logic                 found;
        rr_pick = last;
        found   = 1'b0;
        for (int unsigned i = 1; i <= 4; i++) begin
            idx = last + SEL_WIDTH'(i);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/mux_4_to_1.sv
// Plain 4-to-1 word mux steered by the collector's registered select.
module mux_4_to_1
    import cdc_mux_pkg::*;
#(
    parameter  int INPUT_BIT_LENGTH = 1,
    localparam int W = (INPUT_BIT_LENGTH <= 0) ? 1 : INPUT_BIT_LENGTH
) (
    input  logic [W-1:0]         a,
    input  logic [W-1:0]         b,
    input  logic [W-1:0]         c,
    input  logic [W-1:0]         d,
    input  logic [SEL_WIDTH-1:0] sel,
    output logic [W-1:0]         z
);

    always_comb begin
        z = '0;
        case (sel)
            SRC_A:   z = a;
            SRC_B:   z = b;
            SRC_C:   z = c;
            SRC_D:   z = d;
            default: z = '0;
        endcase
    end

endmodule

// File: rtl/mux_4_rr_collector.sv
// Round-robin collector: grants one of four sources, steers the mux select,
// registers the chosen word and holds it on a valid/ready output until taken.
module mux_4_rr_collector
    import cdc_mux_pkg::*;
#(
    parameter  int INPUT_BIT_LENGTH = 1,
    localparam int W = (INPUT_BIT_LENGTH <= 0) ? 1 : INPUT_BIT_LENGTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           req,
    input  logic [W-1:0]         a,
    input  logic [W-1:0]         b,
    input  logic [W-1:0]         c,
    input  logic [W-1:0]         d,
    output logic [3:0]           ack,
    output logic [SEL_WIDTH-1:0] sel,
    output logic [W-1:0]         out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    collector_state_t     state;
    logic [SEL_WIDTH-1:0] last;
    logic [W-1:0]         mux_z;
    logic [3:0]           masked_req;
    logic [SEL_WIDTH-1:0] pick_idle;
    logic [SEL_WIDTH-1:0] pick_drain;

    mux_4_to_1 #(
        .INPUT_BIT_LENGTH(INPUT_BIT_LENGTH)
    ) u_mux (
        .a  (a),
        .b  (b),
        .c  (c),
        .d  (d),
        .sel(sel),
        .z  (mux_z)
    );

    // The source acked this cycle still shows its old req; masking it here
    // keeps that stale request from winning the back-to-back grant.
    assign masked_req = req & ~ack;
    assign pick_idle  = rr_pick(masked_req, last);
    assign pick_drain = rr_pick(masked_req, sel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= SRC_A;
            last      <= SRC_D;
            ack       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack <= '0;
                    if (|masked_req) begin
                        sel   <= pick_idle;
                        state <= CAPTURE;
                        busy  <= 1'b1;
                    end
                end
                CAPTURE: begin
                    out_data  <= mux_z;
                    out_valid <= 1'b1;
                    ack       <= '0;
                    ack[sel]  <= 1'b1;
                    state     <= DRAIN;
                    busy      <= 1'b1;
                end
                DRAIN: begin
                    ack <= '0;
                    // The accepted grant becomes the rotation origin for this
                    // same-cycle pick, so pick_drain scans from sel, not last.
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        last      <= sel;
                        if (|masked_req) begin
                            sel   <= pick_drain;
                            state <= CAPTURE;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    ack   <= '0;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_4_rr_collector.sv
// Scoreboard bench for mux_4_rr_collector: expected words are queued as sources
// are driven and popped whenever the collector acks a captured word.
module tb_mux_4_rr_collector;

    localparam int W = 8;

    typedef struct packed {
        logic [1:0]   src;
        logic [W-1:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req;
    logic [W-1:0] src_data [4];
    logic [W-1:0] a, b, c, d;
    logic [3:0]   ack;
    logic [1:0]   sel;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         busy;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   words_left [4];
    int   hold_extra [4];
    int   cnt_after  [4];
    int   word_idx   [4];
    int   ack_count  [4];

    assign a = src_data[0];
    assign b = src_data[1];
    assign c = src_data[2];
    assign d = src_data[3];

    always #5 clk = ~clk;

    mux_4_rr_collector #(
        .INPUT_BIT_LENGTH(W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .ack      (ack),
        .sel      (sel),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy)
    );

    function automatic logic [W-1:0] data_of(input int i, input int k);
        return W'((i + 1) * 16 + k);
    endfunction

    task automatic push_exp(input logic [1:0] s, input logic [W-1:0] v);
        exp_t e;
        e.src  = s;
        e.data = v;
        sb.push_back(e);
    endtask

    // One cycle: sample on the falling edge, consume the scoreboard on an ack,
    // then let each source react in the cycle after its ack.
    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (rst_n === 1'b1 && ack !== 4'b0000) begin
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL sb_unexpected_ack: cycle %0d ack=%b busy=%b, required no ack", cyc, ack, busy);
            end else begin
                e = sb.pop_front();
                if (ack !== (4'b0001 << e.src) || out_data !== e.data || out_valid !== 1'b1 || busy !== 1'b1) begin
                    mismatched++;
                    $display("FAIL sb_word: cycle %0d ack=%b out_data=%h out_valid=%b busy=%b, required ack=%b out_data=%h out_valid=1 busy=1",
                             cyc, ack, out_data, out_valid, busy, 4'b0001 << e.src, e.data);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (cnt_after[i] > 0) begin
                cnt_after[i]--;
                if (cnt_after[i] == 0) begin
                    if (words_left[i] > 0) begin
                        words_left[i]--;
                        word_idx[i]++;
                        src_data[i] = data_of(i, word_idx[i]);
                    end else begin
                        req[i] = 1'b0;
                    end
                end
            end
            if (rst_n === 1'b1 && ack[i] === 1'b1) begin
                cnt_after[i] = 1 + hold_extra[i];
                ack_count[i]++;
            end
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = 4'b0000;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            words_left[i] = 0;
            hold_extra[i] = 0;
            cnt_after[i]  = 0;
            word_idx[i]   = 0;
            ack_count[i]  = 0;
            src_data[i]   = '0;
        end
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        compared++;
        if ({busy, out_valid, ack, sel, out_data} !== '0) begin
            mismatched++;
            $display("FAIL reset_state: busy=%b out_valid=%b ack=%b sel=%0d out_data=%h, required all zero",
                     busy, out_valid, ack, sel, out_data);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            compared++;
            if ({busy, out_valid, ack, sel} !== '0) begin
                mismatched++;
                $display("FAIL reset_idle: cycle %0d busy=%b out_valid=%b ack=%b sel=%0d, required 0 0 0000 0",
                         k, busy, out_valid, ack, sel);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        src_data[2] = 8'h5A;
        req         = 4'b0100;
        push_exp(2'd2, 8'h5A);
        step();
        compared++;
        if (sel !== 2'd2 || busy !== 1'b1 || out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL single_capture: sel=%0d busy=%b out_valid=%b, required sel=2 busy=1 out_valid=0", sel, busy, out_valid);
        end
        step();
        compared++;
        if (out_data !== 8'h5A || out_valid !== 1'b1 || ack !== 4'b0100) begin
            mismatched++;
            $display("FAIL single_output: out_data=%h out_valid=%b ack=%b, required 5a 1 0100", out_data, out_valid, ack);
        end
        step();
        compared++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || ack !== 4'b0000) begin
            mismatched++;
            $display("FAIL single_idle: busy=%b out_valid=%b ack=%b, required 0 0 0000", busy, out_valid, ack);
        end
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL single_drain: %0d words pending, required 0", sb.size());
        end
    endtask

    task automatic test_round_robin();
        logic exp_v;
        int   prev_ack;
        do_reset();
        prev_ack = 0;
        for (int i = 0; i < 4; i++) src_data[i] = data_of(i, 0);
        words_left[0] = 1;
        req = 4'b1111;
        push_exp(2'd0, data_of(0, 0));
        push_exp(2'd1, data_of(1, 0));
        push_exp(2'd2, data_of(2, 0));
        push_exp(2'd3, data_of(3, 0));
        push_exp(2'd0, data_of(0, 1));
        for (int k = 1; k <= 14; k++) begin
            step();
            exp_v = (k >= 2 && k <= 10 && (k % 2) == 0);
            compared++;
            if (out_valid !== exp_v) begin
                mismatched++;
                $display("FAIL rr_valid_alt: cycle %0d out_valid=%b, required %b", k, out_valid, exp_v);
            end
            if (ack !== 4'b0000) begin
                if (prev_ack > 0) begin
                    compared++;
                    if (k - prev_ack != 2) begin
                        mismatched++;
                        $display("FAIL rr_spacing: ack at cycle %0d after %0d, required gap 2", k, prev_ack);
                    end
                end
                prev_ack = k;
            end
        end
        compared++;
        if (sb.size() != 0 || ack_count[0] != 2 || ack_count[1] != 1 || ack_count[2] != 1 || ack_count[3] != 1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL rr_totals: pending=%0d acks=%0d/%0d/%0d/%0d busy=%b, required 0 2/1/1/1 0",
                     sb.size(), ack_count[0], ack_count[1], ack_count[2], ack_count[3], busy);
        end
    endtask

    task automatic test_stale_mask();
        do_reset();
        src_data[1] = 8'hB1;
        req         = 4'b0010;
        push_exp(2'd1, 8'hB1);
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 3) begin
                compared++;
                if (busy !== 1'b0) begin
                    mismatched++;
                    $display("FAIL stale_no_regrant: cycle 3 busy=%b, required 0", busy);
                end
            end
        end
        compared++;
        if (ack_count[1] != 1 || sb.size() != 0) begin
            mismatched++;
            $display("FAIL stale_once: b acks=%0d pending=%0d, required 1 0", ack_count[1], sb.size());
        end
        // b now lingers into IDLE, then drops req before its second ack
        hold_extra[1] = 1;
        src_data[1]   = 8'hB2;
        req[1]        = 1'b1;
        push_exp(2'd1, 8'hB2);
        push_exp(2'd1, 8'hB2);
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 3) begin
                compared++;
                if (busy !== 1'b0) begin
                    mismatched++;
                    $display("FAIL stale_regrant_idle: cycle 3 busy=%b, required 0", busy);
                end
            end
        end
        compared++;
        if (ack_count[1] != 3 || sb.size() != 0) begin
            mismatched++;
            $display("FAIL stale_regrant: b acks=%0d pending=%0d, required 3 0", ack_count[1], sb.size());
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready   = 1'b0;
        src_data[0] = 8'hC3;
        src_data[1] = 8'h77;
        req         = 4'b0011;
        push_exp(2'd0, 8'hC3);
        push_exp(2'd1, 8'h77);
        step();
        step();
        for (int k = 1; k <= 5; k++) begin
            step();
            compared++;
            if (out_valid !== 1'b1 || out_data !== 8'hC3 || sel !== 2'd0 || ack !== 4'b0000) begin
                mismatched++;
                $display("FAIL bp_hold: stall %0d out_valid=%b out_data=%h sel=%0d ack=%b, required 1 c3 0 0000",
                         k, out_valid, out_data, sel, ack);
            end
        end
        out_ready = 1'b1;
        step();
        compared++;
        if (sel !== 2'd1 || out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL bp_release: sel=%0d out_valid=%b, required 1 0", sel, out_valid);
        end
        for (int k = 0; k < 6 && sb.size() != 0; k++) step();
        compared++;
        if (sb.size() != 0 || ack_count[0] != 1) begin
            mismatched++;
            $display("FAIL bp_drain: pending=%0d a acks=%0d, required 0 1", sb.size(), ack_count[0]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        src_data[2] = 8'h3C;
        req         = 4'b0100;
        push_exp(2'd2, 8'h3C);
        for (int k = 0; k < 4; k++) step();
        src_data[1] = 8'hB5;
        src_data[3] = 8'hD5;
        req         = 4'b1010;
        step();
        compared++;
        if (sel !== 2'd3 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_pick_d: sel=%0d busy=%b, required 3 1", sel, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        if ({out_valid, ack, sel, busy, out_data} !== '0) begin
            mismatched++;
            $display("FAIL mid_async_clear: out_valid=%b ack=%b sel=%0d busy=%b out_data=%h, required all zero",
                     out_valid, ack, sel, busy, out_data);
        end
        @(negedge clk);
        @(negedge clk);
        compared++;
        if ({out_valid, ack, busy} !== '0) begin
            mismatched++;
            $display("FAIL mid_held_reset: out_valid=%b ack=%b busy=%b, required 0 0000 0", out_valid, ack, busy);
        end
        rst_n = 1'b1;
        push_exp(2'd1, 8'hB5);
        push_exp(2'd3, 8'hD5);
        step();
        compared++;
        if (sel !== 2'd1 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_first_after_reset: sel=%0d busy=%b, required 1 1", sel, busy);
        end
        for (int k = 0; k < 10 && sb.size() != 0; k++) step();
        compared++;
        if (sb.size() != 0 || ack_count[3] != 1 || ack_count[1] != 1) begin
            mismatched++;
            $display("FAIL mid_drain: pending=%0d b acks=%0d d acks=%0d, required 0 1 1", sb.size(), ack_count[1], ack_count[3]);
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        req       = 4'b0000;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) src_data[i] = '0;
        #1;
        rst_n = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_stale_mask();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
